// File: rtl/lbc_pkg.sv
// Shared constants and FSM state type for the line-buffer controller and the
// position counter reused by the 3x3 kernel.
package lbc_pkg;

    localparam int LBC_WIDTH = 8;
    localparam int LBC_COL   = 752;
    localparam int LBC_ROW   = 480;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } lbc_state_e;

endpackage

// File: rtl/lbc_pos_cnt.sv
// Row/column position counter: col wraps at COL-1, row counts 0..ROW so the
// flush pass can run on row ROW before wrapping back to 0.
module lbc_pos_cnt import lbc_pkg::*; #(
    parameter  int COL = LBC_COL,
    parameter  int ROW = LBC_ROW,
    localparam int CW  = $clog2(COL),
    localparam int RW  = $clog2(ROW + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last_col,
    output logic          o_last_row
);

    localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROW - 1);
    localparam logic [RW-1:0] END_ROW  = RW'(ROW);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_last_col;

    assign w_last_col = (r_col == LAST_COL);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_inc) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= (r_row == END_ROW) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last_col = w_last_col;
    assign o_last_row = (r_row == LAST_ROW);

endmodule

// File: rtl/line_buf_ctrl.sv
// Frame sequencer for the img_buffer line-buffer chain feeding the 3x3 kernel.
// Optional LBC_FLUSH_REPLICATE_EN: flush writes replay mid_tap instead of zeros.
module line_buf_ctrl import lbc_pkg::*; #(
    parameter int WIDTH = LBC_WIDTH,
    parameter int COL   = LBC_COL,
    parameter int ROW   = LBC_ROW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sof,
    input  logic             pix_valid,
    input  logic [WIDTH-1:0] pix,
    input  logic [WIDTH-1:0] mid_tap,
    output logic             ready,
    output logic             buf_en,
    output logic             buf_wr,
    output logic [WIDTH-1:0] buf_din,
    output logic             tap_valid,
    output logic             top,
    output logic             bottom,
    output logic             left,
    output logic             right,
    output logic             frame_done,
    output logic             frame_err
);

    localparam int CW = $clog2(COL);
    localparam int RW = $clog2(ROW + 1);
    localparam logic [RW-1:0] FLUSH_ROW = RW'(ROW);

    lbc_state_e    r_state;
    lbc_state_e    w_next;
    logic          r_err;
    logic          w_run;
    logic          w_flush;
    logic          w_src_wr;
    logic          w_wr;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last_col;
    logic          w_last_row;

    assign w_run    = (r_state == S_RUN);
    assign w_flush  = (r_state == S_FLUSH);
    assign w_src_wr = w_run && pix_valid;
    assign w_wr     = w_src_wr || w_flush;

    lbc_pos_cnt #(
        .COL (COL),
        .ROW (ROW)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == S_CLR),
        .i_inc      (w_wr),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last_col (w_last_col),
        .o_last_row (w_last_row)
    );

    // sof from any state restarts the clear cycle; only RUN/FLUSH treat it as an abort
    always_comb begin
        w_next = r_state;
        if (sof) begin
            w_next = S_CLR;
        end else begin
            unique case (r_state)
                S_IDLE:  w_next = S_IDLE;
                S_CLR:   w_next = S_RUN;
                S_RUN:   if (pix_valid && w_last_col && w_last_row) w_next = S_FLUSH;
                S_FLUSH: if (w_last_col) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (sof && (r_state == S_IDLE)) begin
            r_err <= 1'b0;
        end else if ((sof && (w_run || w_flush)) || (pix_valid && w_flush)) begin
            r_err <= 1'b1;
        end
    end

`ifdef LBC_FLUSH_REPLICATE_EN
    always_comb begin
        buf_din = '0;
        if (w_src_wr) begin
            buf_din = pix;
        end else if (w_flush) begin
            buf_din = mid_tap;
        end
    end
`else
    logic w_unused_mid_tap;
    assign w_unused_mid_tap = ^mid_tap;

    always_comb begin
        buf_din = '0;
        if (w_src_wr) begin
            buf_din = pix;
        end
    end
`endif

    // taps hold a full column triple only once row 0 has been written
    assign tap_valid  = w_wr && (w_row != '0);
    assign top        = tap_valid && (w_row == RW'(1));
    assign bottom     = tap_valid && (w_row == FLUSH_ROW);
    assign left       = tap_valid && (w_col == '0);
    assign right      = tap_valid && w_last_col;

    assign ready      = w_run;
    assign buf_en     = !(rst || (r_state == S_CLR));
    assign buf_wr     = w_wr;
    assign frame_done = (r_state == S_DONE);
    assign frame_err  = r_err;

endmodule
